// File: rtl/dmem_responder.sv
// Purpose: serialized load/store data memory behind valid/ready request and response channels.
// Latency: RSP_VALID rises LATENCY+1 edges after acceptance; requests are not pipelined.
// Backpressure: REQ_READY is high only in IDLE; the response is held until RSP_READY.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   REQ_VALID/READY   request handshake; REQ_WE, REQ_ADDR, REQ_SIZE, REQ_UNSIGNED, REQ_WDATA
//                     are sampled only on the acceptance edge
//   RSP_VALID/READY   response handshake; RSP_RDATA (load result), RSP_ERR (misaligned)
module dmem_responder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [DEPTH_LOG2+2:0] REQ_ADDR,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [63:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [63:0]           RSP_RDATA,
  output logic                  RSP_ERR
);

  localparam int AW     = DEPTH_LOG2 + 3;
  localparam int NWORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [63:0]     mem_q [NWORDS];

  logic            accept;
  logic            commit;
  logic            mem_we;

  // Commit operands: with zero wait states the commit happens on the
  // acceptance edge itself, so the live request fields are used while IDLE.
  logic            c_we;
  logic [AW-1:0]   c_addr;
  logic [1:0]      c_size;
  logic            c_uns;
  logic [63:0]     c_wdata;

  logic [DEPTH_LOG2-1:0] c_idx;
  logic [2:0]      c_off;
  logic [5:0]      sh_amt;
  logic            misaligned;
  logic [63:0]     rd_word;
  logic [63:0]     rd_shift;
  logic [63:0]     load_val;
  logic [7:0]      size_mask;
  logic [7:0]      byte_en;
  logic [63:0]     bit_mask;
  logic [63:0]     wr_shift;
  logic [63:0]     merged;

  always_comb begin
    if (state_q == IDLE) begin
      c_we    = REQ_WE;
      c_addr  = REQ_ADDR;
      c_size  = REQ_SIZE;
      c_uns   = REQ_UNSIGNED;
      c_wdata = REQ_WDATA;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_size  = size_q;
      c_uns   = uns_q;
      c_wdata = wdata_q;
    end
  end

  assign c_idx  = c_addr[AW-1:3];
  assign c_off  = c_addr[2:0];
  assign sh_amt = {c_off, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    case (c_size)
      2'd1:    misaligned = c_off[0];
      2'd2:    misaligned = |c_off[1:0];
      2'd3:    misaligned = |c_off;
      default: misaligned = 1'b0;
    endcase
  end

  // Load path: bring the addressed bytes down to bit 0, then extend.
  assign rd_word  = mem_q[c_idx];
  assign rd_shift = rd_word >> sh_amt;

  always_comb begin
    load_val = 64'd0;
    case (c_size)
      2'd0:    load_val = c_uns ? {56'd0, rd_shift[7:0]}
                                : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_val = c_uns ? {48'd0, rd_shift[15:0]}
                                : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_val = c_uns ? {32'd0, rd_shift[31:0]}
                                : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Store path: byte-enable read-modify-write of the addressed word. An
  // aligned access never crosses the word, so the shifted mask stays in range.
  always_comb begin
    size_mask = 8'h00;
    case (c_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign byte_en  = size_mask << c_off;
  assign wr_shift = c_wdata << sh_amt;

  always_comb begin
    bit_mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_en[i]}};
    end
  end

  assign merged = (rd_word & ~bit_mask) | (wr_shift & bit_mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rdata_d = 64'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = misaligned;
      rdata_d = (misaligned || c_we) ? 64'd0 : load_val;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= REQ_WE;
        addr_q  <= REQ_ADDR;
        size_q  <= REQ_SIZE;
        uns_q   <= REQ_UNSIGNED;
        wdata_q <= REQ_WDATA;
      end
    end
  end

  // Storage is not reset; the write enable is qualified with RST_N so an
  // edge arriving while reset is held can never commit a store.
  assign mem_we = commit && c_we && !misaligned && RST_N;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[c_idx] <= merged;
    end
  end

  assign REQ_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_valid0 = 1'b0;
  logic          rsp_ready = 1'b0;
  logic          rsp_ready0 = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [63:0]   req_wdata = 64'd0;

  logic          req_ready, rsp_valid, rsp_err;
  logic [63:0]   rsp_rdata;
  logic          req_ready0, rsp_valid0, rsp_err0;
  logic [63:0]   rsp_rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(5), .LATENCY(2)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
    .RSP_ERR(rsp_err)
  );

  dmem_responder #(.DEPTH_LOG2(5), .LATENCY(0)) dut0 (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid0), .REQ_READY(req_ready0), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid0), .RSP_READY(rsp_ready0), .RSP_RDATA(rsp_rdata0),
    .RSP_ERR(rsp_err0)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction on the selected instance (inst=1 -> LATENCY=0).
  // exp_lat counts edges from the acceptance edge (inclusive) to RSP_VALID.
  task automatic xact(input bit inst, input bit we, input logic [AW-1:0] addr,
                      input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                      input logic [63:0] exp_rdata, input bit exp_err,
                      input int exp_lat, input int hold, input string tag);
    exp_t        e;
    int          n;
    logic [63:0] held;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);

    @(negedge clk);
    chk({tag, "/req_ready_before"}, inst ? req_ready0 : req_ready, 64'd1);
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    if (inst) req_valid0 = 1'b1;
    else      req_valid  = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid    = 1'b0;
    req_valid0   = 1'b0;
    // Scramble request fields: they must be ignored after acceptance.
    req_we       = 1'b1;
    req_addr     = AW'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = {$urandom, $urandom};
    while (!(inst ? rsp_valid0 : rsp_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 64'(n), 64'(exp_lat));

    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "/rdata"}, inst ? rsp_rdata0 : rsp_rdata, e.rdata);
      chk({tag, "/err"}, 64'(inst ? rsp_err0 : rsp_err), 64'(e.err));
    end

    held = inst ? rsp_rdata0 : rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "/hold_valid"}, 64'(inst ? rsp_valid0 : rsp_valid), 64'd1);
      chk({tag, "/hold_rdata"}, inst ? rsp_rdata0 : rsp_rdata, held);
      chk({tag, "/hold_req_ready"}, 64'(inst ? req_ready0 : req_ready), 64'd0);
    end

    if (inst) rsp_ready0 = 1'b1;
    else      rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready  = 1'b0;
    rsp_ready0 = 1'b0;
    chk({tag, "/valid_after"}, 64'(inst ? rsp_valid0 : rsp_valid), 64'd0);
    chk({tag, "/req_ready_after"}, 64'(inst ? req_ready0 : req_ready), 64'd1);
    chk({tag, "/rdata_after"}, inst ? rsp_rdata0 : rsp_rdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset/req_ready", 64'(req_ready), 64'd1);
    chk("reset/rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset/rsp_rdata", rsp_rdata, 64'd0);
    chk("reset/rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;

    // Double store/load round trip with latency check.
    xact(0, 1, 8'h08, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 3, 0, "st_d_08");
    xact(0, 0, 8'h08, 2'd3, 0, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 3, 0, "ld_d_08");
    // Sub-word loads with sign / zero extension.
    xact(0, 0, 8'h08, 2'd0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFEF, 0, 3, 0, "ld_bs_08");
    xact(0, 0, 8'h08, 2'd0, 1, 64'd0, 64'h0000_0000_0000_00EF, 0, 3, 0, "ld_bu_08");
    xact(0, 0, 8'h0E, 2'd1, 0, 64'd0, 64'h0000_0000_0000_0123, 0, 3, 0, "ld_hs_0e");
    // Byte merge leaves neighbours alone.
    xact(0, 1, 8'h09, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FFAA, 64'd0, 0, 3, 0, "st_b_09");
    xact(0, 0, 8'h08, 2'd3, 0, 64'd0, 64'h0123_4567_89AB_AAEF, 0, 3, 0, "ld_d_08b");
    // Misaligned load, then an aligned word store.
    xact(0, 0, 8'h0A, 2'd2, 0, 64'd0, 64'd0, 1, 3, 0, "ld_w_0a_mis");
    xact(0, 1, 8'h0C, 2'd2, 0, 64'h1234_5678_CAFE_BABE, 64'd0, 0, 3, 0, "st_w_0c");
    xact(0, 0, 8'h08, 2'd3, 0, 64'd0, 64'hCAFE_BABE_89AB_AAEF, 0, 3, 0, "ld_d_08c");
    xact(0, 0, 8'h08, 2'd2, 0, 64'd0, 64'hFFFF_FFFF_89AB_AAEF, 0, 3, 0, "ld_ws_08");
    xact(0, 0, 8'h0C, 2'd2, 1, 64'd0, 64'h0000_0000_CAFE_BABE, 0, 3, 0, "ld_wu_0c");
    xact(0, 0, 8'h0A, 2'd1, 1, 64'd0, 64'h0000_0000_0000_89AB, 0, 3, 0, "ld_hu_0a");
    // Misaligned store must not touch word 0.
    xact(0, 1, 8'h00, 2'd3, 0, 64'h5555_6666_7777_8888, 64'd0, 0, 3, 0, "st_d_00");
    xact(0, 1, 8'h04, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 3, 0, "st_d_04_mis");
    xact(0, 0, 8'h00, 2'd3, 0, 64'd0, 64'h5555_6666_7777_8888, 0, 3, 0, "ld_d_00");
    // Response back-pressure for five cycles.
    xact(0, 0, 8'h08, 2'd3, 0, 64'd0, 64'hCAFE_BABE_89AB_AAEF, 0, 3, 5, "hold_ld");

    // Reset during WAIT of a store aborts it asynchronously.
    xact(0, 1, 8'h10, 2'd3, 0, 64'h1111_2222_3333_4444, 64'd0, 0, 3, 0, "st_d_10");
    @(negedge clk);
    req_we = 1'b1; req_addr = 8'h10; req_size = 2'd3; req_unsigned = 1'b0;
    req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    chk("abort/in_wait_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort/req_ready", 64'(req_ready), 64'd1);
    chk("abort/rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort/rsp_rdata", rsp_rdata, 64'd0);
    chk("abort/rsp_err", 64'(rsp_err), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    xact(0, 0, 8'h10, 2'd3, 0, 64'd0, 64'h1111_2222_3333_4444, 0, 3, 0, "ld_d_10");

    // Zero wait states: response right after the acceptance edge.
    xact(1, 1, 8'h18, 2'd3, 0, 64'hA5A5_0F0F_1234_8001, 64'd0, 0, 1, 0, "l0_st_d_18");
    xact(1, 0, 8'h1E, 2'd1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_A5A5, 0, 1, 0, "l0_ld_hs_1e");
    xact(1, 0, 8'h19, 2'd1, 0, 64'd0, 64'd0, 1, 1, 2, "l0_ld_h_19_mis");

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that serves load/store requests from the load/store datapath over a valid/ready request channel and a valid/ready response channel. It holds 2^DEPTH_LOG2 doublewords of storage and supports byte, half, word and double accesses. Loads can be sign- or zero-extended, and misaligned accesses are rejected. Programmable wait states model a slow memory so the datapath control unit can be exercised against back-pressure.

Parameters:
DEPTH_LOG2, 5, log2 of the number of 64-bit storage words; byte address width is DEPTH_LOG2+3.
LATENCY, 2, wait-state cycles between request acceptance and response; legal range 0..15.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST_N  input  1  asynchronous, active-low reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  responder can accept a request.
REQ_WE  input  1  1 = store, 0 = load.
REQ_ADDR  input  DEPTH_LOG2+3  byte address.
REQ_SIZE  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ_UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
REQ_WDATA  input  64  store data, right-aligned (low bytes used).
RSP_VALID  output  1  response present.
RSP_READY  input  1  requester accepts response.
RSP_RDATA  output  64  load result; 0 for stores and errors.
RSP_ERR  output  1  access was misaligned.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low. Reset forces state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, wait counter=0.
- Storage contents are not reset.
- Reset asserted mid-transaction aborts it. A store aborted before its commit edge must not modify storage.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - REQ_READY=1.
  - On an edge with REQ_VALID=1, latch WE/ADDR/SIZE/UNSIGNED/WDATA and check alignment.
  - Go to WAIT with counter=LATENCY-1 when LATENCY>0. When LATENCY=0, commit (see below) on this same edge and go to RESP.
- WAIT:
  - REQ_READY=0.
  - Counter decrements each edge.
  - On the edge where counter==0, commit and go to RESP.
- Commit:
  - Aligned store: merge the low 1/2/4/8 bytes of WDATA into the addressed word at byte offset ADDR[2:0]. Other bytes are unchanged. RSP_RDATA=0, RSP_ERR=0.
  - Aligned load: extract the addressed bytes, then sign- or zero-extend to 64 bits into RSP_RDATA. RSP_ERR=0.
  - Misaligned: ADDR not a multiple of the access size (half: ADDR[0]!=0; word: ADDR[1:0]!=0; double: ADDR[2:0]!=0). Storage is untouched, RSP_RDATA=0, RSP_ERR=1.
- RESP:
  - RSP_VALID=1, REQ_READY=0.
  - RSP_RDATA and RSP_ERR are held stable until the handshake.
  - On an edge with RSP_READY=1: RSP_VALID→0, RSP_RDATA→0, RSP_ERR→0, go to IDLE.
  - RSP_READY may be held high in advance; the handshake then completes on the first RESP edge.
- Latency: RSP_VALID rises LATENCY+1 edges after the acceptance edge. Minimum request spacing is LATENCY+2 cycles; no pipelining.
- Request-side inputs are sampled only on the acceptance edge. Changes afterwards are ignored.
- REQ_VALID asserted while not in IDLE is not accepted. The requester must hold it until REQ_READY.
- Load after store to the same address returns the new data; there are no hazards because accesses are serialized.
- Address wraps naturally within DEPTH_LOG2+3 bits. There is no out-of-range error.

Test Plan:
- Store double 0x0123_4567_89AB_CDEF at addr 0x08, then load double from 0x08 → RSP_RDATA=0x0123456789ABCDEF, RSP_ERR=0, RSP_VALID rises exactly 3 edges after acceptance (LATENCY=2).
- After the above, load byte signed from 0x08 → 0xFFFF_FFFF_FFFF_FFEF; load byte unsigned → 0x0000_0000_0000_00EF; load half signed from 0x0E → 0x0000_0000_0000_0123.
- Store byte 0xAA at 0x09, then load double from 0x08 → 0x0123456789ABAAEF; neighbouring bytes are unchanged.
- Load word from 0x0A (misaligned) → RSP_ERR=1, RSP_RDATA=0. A following store-word to 0x0C with RSP_ERR expected 0 succeeds, and a misaligned store-double to 0x04 leaves storage unchanged.
- Hold RSP_READY=0 for 5 cycles during RESP → RSP_VALID stays 1 with stable data and REQ_READY stays 0. Raise RSP_READY → one edge later RSP_VALID=0 and REQ_READY=1.
- Assert RST_N=0 while in WAIT of a store to 0x10 → outputs return to reset values immediately (asynchronously), and a later load of 0x10 returns its prior contents. With LATENCY=0, the response appears on the edge after acceptance.
